pci_initiator_burst: RTL and testbench

- Parametrised PCI bus initiator (master) controller; successor to the fixed 4-word read-only initiator.
- Performs single or burst memory read or write transactions of 1..MAX_BURST data phases.
- Handles arbitration (req_n/gnt_n), address phase, turnaround, target wait states, and master abort on DEVSEL timeout.
- Sits between a local command interface (start/done, write buffer, read stream) and the shared PCI AD/C_BE/FRAME/IRDY lines.

---
 rtl/pci_initiator_burst.sv | 193 +++++++++++++++++++
 tb/tb_pci_initiator_burst.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pci_initiator_burst.sv
// PCI bus initiator: single or burst memory read/write of 1..MAX_BURST
// data phases, with arbitration, turnaround, wait states and master abort.
module pci_initiator_burst #(
  parameter int MAX_BURST      = 8,
  parameter int LEN_W          = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_wr,
  input  logic [31:0]      addr,
  input  logic [3:0]       be,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [31:0]      wdata,
  input  logic             wdata_we,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             req_n,
  input  logic             gnt_n,
  inout  wire              frame_n,
  inout  wire              irdy_n,
  input  logic             trdy_n,
  input  logic             devsel_n,
  inout  wire  [31:0]      ad,
  output logic [3:0]       c_be
);

  localparam int PW = $clog2(MAX_BURST);
  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, TURN, DATA, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic             rd_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [LEN_W-1:0] rem_q;
  logic [CW-1:0]    dcnt_q;
  logic             devok_q, abort_q;
  logic [31:0]      buf_q [MAX_BURST];
  logic [PW:0]      wp_q, rp_q;
  logic [31:0]      rdata_q;
  logic             rvalid_q, done_q, err_q;

  logic        legal, xfer, last, full;
  logic        own, frame_c, irdy_c, ad_oe;
  logic [31:0] ad_c;
  logic [3:0]  cbe_c;

  assign legal = (burst_len != '0) &&
                 ({1'b0, burst_len} <= (LEN_W+1)'(MAX_BURST));
  assign xfer  = (state_q == DATA) && !trdy_n && !abort_q;
  assign last  = (rem_q == LEN_W'(1));
  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && legal) state_d = REQ;
      REQ:     if (!gnt_n && frame_n && irdy_n) state_d = ADDR;
      ADDR:    state_d = rd_q ? TURN : DATA;
      TURN:    state_d = DATA;
      DATA:    if (abort_q || (xfer && last)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_n   = 1'b1;
    own     = 1'b0;
    frame_c = 1'b1;
    irdy_c  = 1'b1;
    ad_oe   = 1'b0;
    ad_c    = '0;
    cbe_c   = be_q;
    unique case (state_q)
      REQ:  req_n = 1'b0;
      ADDR: begin
        own     = 1'b1;
        frame_c = 1'b0;
        ad_oe   = 1'b1;
        ad_c    = addr_q;
        cbe_c   = rd_q ? 4'b0110 : 4'b0111;
      end
      TURN: begin
        own     = 1'b1;
        frame_c = 1'b0;
        irdy_c  = 1'b0;
      end
      DATA: begin
        own     = 1'b1;
        irdy_c  = 1'b0;
        frame_c = abort_q | last;
        ad_oe   = !rd_q;
        ad_c    = buf_q[rp_q[PW-1:0]];
      end
      FINISH:  own = 1'b1;
      default: ;
    endcase
  end

  assign frame_n     = own   ? frame_c : 1'bz;
  assign irdy_n      = own   ? irdy_c  : 1'bz;
  assign ad          = ad_oe ? ad_c    : 32'bz;
  assign c_be        = own   ? cbe_c   : 4'bz;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign error       = err_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      rem_q    <= '0;
      dcnt_q   <= '0;
      devok_q  <= 1'b0;
      abort_q  <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_BURST; i++) buf_q[i] <= '0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      if (state_q == IDLE && wdata_we && !full) begin
        buf_q[wp_q[PW-1:0]] <= wdata;
        wp_q <= wp_q + 1'b1;
      end
      if (state_q == IDLE && start) begin
        if (legal) begin
          rd_q   <= rd_wr;
          addr_q <= addr;
          be_q   <= be;
          rem_q  <= burst_len;
        end else begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
          wp_q   <= '0;
          rp_q   <= '0;
        end
      end
      if (state_q == ADDR) begin
        dcnt_q  <= '0;
        devok_q <= 1'b0;
        abort_q <= 1'b0;
      end
      // DEVSEL watchdog runs from the first clock after the address phase
      if ((state_q == TURN || state_q == DATA) && !devok_q && !abort_q) begin
        if (!devsel_n) devok_q <= 1'b1;
        else begin
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q + 1'b1 == CW'(DEVSEL_TIMEOUT)) abort_q <= 1'b1;
        end
      end
      if (xfer) begin
        rem_q <= rem_q - 1'b1;
        if (rd_q) begin
          rdata_q  <= ad;
          rvalid_q <= 1'b1;
        end else begin
          rp_q <= rp_q + 1'b1;
        end
      end
      if (state_q == FINISH) begin
        done_q <= 1'b1;
        err_q  <= abort_q;
        wp_q   <= '0;
        rp_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pci_initiator_burst.sv
// Directed bench for pci_initiator_burst; released bus lines float high
// through pull-up nets, so an undriven ad/c_be reads as all ones.
module tb_pci_initiator_burst;

  logic        clk = 1'b0;
  logic        rst, start, rd_wr, wdata_we, gnt_n, trdy_n, devsel_n;
  logic [31:0] addr, wdata, rdata, tgt_ad;
  logic [3:0]  be, burst_len;
  logic        rdata_valid, busy, done, error, req_n, tgt_oe;
  tri1         frame_n, irdy_n;
  tri1 [31:0]  ad;
  tri1 [3:0]   c_be;
  int          n_cmp = 0, n_bad = 0, rv_cnt = 0, rv0;

  assign ad = tgt_oe ? tgt_ad : 32'bz;

  always #5 clk = ~clk;

  always @(negedge clk) if (rdata_valid) rv_cnt++;

  pci_initiator_burst dut (
    .clk(clk), .rst(rst), .start(start), .rd_wr(rd_wr),
    .addr(addr), .be(be), .burst_len(burst_len),
    .wdata(wdata), .wdata_we(wdata_we),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .error(error),
    .req_n(req_n), .gnt_n(gnt_n),
    .frame_n(frame_n), .irdy_n(irdy_n),
    .trdy_n(trdy_n), .devsel_n(devsel_n),
    .ad(ad), .c_be(c_be)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(logic rw, logic [31:0] a, logic [3:0] b,
                     logic [3:0] len);
    start = 1'b1; rd_wr = rw; addr = a; be = b; burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic push(logic [31:0] w);
    wdata = w; wdata_we = 1'b1;
    tick();
    wdata_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; rd_wr = 1'b0; addr = '0; be = '0;
    burst_len = '0; wdata = '0; wdata_we = 1'b0; gnt_n = 1'b0;
    trdy_n = 1'b0; devsel_n = 1'b0; tgt_oe = 1'b0; tgt_ad = '0;
    tick(); tick();
    check("rst_req_n", req_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame", frame_n, 1);
    check("rst_ad", ad, 32'hFFFF_FFFF);
    check("rst_cbe", c_be, 4'hF);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    tick();

    rv0 = rv_cnt;
    cmd(1'b1, 32'h10, 4'h0, 4'd1);
    check("rd_req_n", req_n, 0);
    check("rd_busy", busy, 1);
    tick();
    check("rd_addr_frame", frame_n, 0);
    check("rd_addr_cbe", c_be, 4'b0110);
    check("rd_addr_ad", ad, 32'h10);
    check("rd_addr_req", req_n, 1);
    tick();
    check("rd_turn_ad", ad, 32'hFFFF_FFFF);
    check("rd_turn_cbe", c_be, 4'h0);
    check("rd_turn_irdy", irdy_n, 0);
    tgt_oe = 1'b1; tgt_ad = 32'hA5A5_0001;
    tick();
    check("rd_data_frame", frame_n, 1);
    check("rd_data_irdy", irdy_n, 0);
    tick();
    tgt_oe = 1'b0;
    check("rd_fin_rvalid", rdata_valid, 1);
    check("rd_fin_rdata", rdata, 32'hA5A5_0001);
    check("rd_fin_irdy", irdy_n, 1);
    tick();
    check("rd_done", done, 1);
    check("rd_err", error, 0);
    check("rd_idle_busy", busy, 0);
    check("rd_idle_cbe", c_be, 4'hF);
    check("rd_rv_count", rv_cnt - rv0, 1);

    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    cmd(1'b0, 32'h100, 4'h0, 4'd4);
    tick();
    check("wr_addr_cbe", c_be, 4'b0111);
    check("wr_addr_ad", ad, 32'h100);
    tick();
    check("wr_p1_ad", ad, 32'h11);
    check("wr_p1_frame", frame_n, 0);
    tick();
    check("wr_p2_ad", ad, 32'h22);
    trdy_n = 1'b1;
    tick();
    check("wr_w1_ad", ad, 32'h22);
    check("wr_w1_frame", frame_n, 0);
    tick();
    check("wr_w2_ad", ad, 32'h22);
    trdy_n = 1'b0;
    tick();
    check("wr_p3_ad", ad, 32'h33);
    check("wr_p3_frame", frame_n, 0);
    tick();
    check("wr_p4_ad", ad, 32'h44);
    check("wr_p4_frame", frame_n, 1);
    tick();
    check("wr_fin_irdy", irdy_n, 1);
    tick();
    check("wr_done", done, 1);
    check("wr_err", error, 0);

    gnt_n = 1'b1;
    cmd(1'b1, 32'h20, 4'h0, 4'd1);
    for (int i = 0; i < 6; i++) begin
      check("arb_req_n", req_n, 0);
      check("arb_frame", frame_n, 1);
      check("arb_ad", ad, 32'hFFFF_FFFF);
      if (i == 5) gnt_n = 1'b0;
      tick();
    end
    check("arb_addr_frame", frame_n, 0);
    check("arb_addr_ad", ad, 32'h20);
    tick();
    tgt_oe = 1'b1; tgt_ad = 32'h5A5A_0002;
    tick();
    tick();
    tgt_oe = 1'b0;
    check("arb_rdata", rdata, 32'h5A5A_0002);
    tick();
    check("arb_done", done, 1);

    devsel_n = 1'b1; trdy_n = 1'b1; rv0 = rv_cnt;
    cmd(1'b1, 32'h30, 4'h0, 4'd4);
    tick();
    tick();
    repeat (4) tick();
    check("ab_c5_frame", frame_n, 0);
    check("ab_c5_irdy", irdy_n, 0);
    tick();
    check("ab_c6_frame", frame_n, 1);
    check("ab_c6_irdy", irdy_n, 0);
    tick();
    check("ab_fin_irdy", irdy_n, 1);
    tick();
    check("ab_done", done, 1);
    check("ab_err", error, 1);
    check("ab_rv_count", rv_cnt - rv0, 0);
    devsel_n = 1'b0; trdy_n = 1'b0;

    cmd(1'b1, 32'h0, 4'h0, 4'd0);
    check("len0_done", done, 1);
    check("len0_err", error, 1);
    check("len0_req_n", req_n, 1);
    check("len0_busy", busy, 0);
    tick();
    check("len0_done_pulse", done, 0);
    cmd(1'b0, 32'h0, 4'h0, 4'd9);
    check("len9_done", done, 1);
    check("len9_err", error, 1);
    check("len9_req_n", req_n, 1);

    for (int i = 1; i <= 8; i++) push(32'h100 + i);
    cmd(1'b0, 32'h40, 4'h0, 4'd8);
    tick();
    tick();
    check("rs_p1_ad", ad, 32'h101);
    tick();
    check("rs_p2_ad", ad, 32'h102);
    check("rs_p2_frame", frame_n, 0);
    rst = 1'b1;
    #1;
    check("rs_frame", frame_n, 1);
    check("rs_irdy", irdy_n, 1);
    check("rs_ad", ad, 32'hFFFF_FFFF);
    check("rs_cbe", c_be, 4'hF);
    check("rs_req_n", req_n, 1);
    check("rs_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    cmd(1'b1, 32'h50, 4'h3, 4'd1);
    tick();
    check("rs2_addr_ad", ad, 32'h50);
    check("rs2_addr_cbe", c_be, 4'b0110);
    tick();
    check("rs2_turn_cbe", c_be, 4'h3);
    tgt_oe = 1'b1; tgt_ad = 32'hC0DE_0003;
    tick();
    tick();
    tgt_oe = 1'b0;
    check("rs2_rdata", rdata, 32'hC0DE_0003);
    tick();
    check("rs2_done", done, 1);
    check("rs2_err", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
